// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Registered 1-cycle lookup for fetch; trained by resolved branches from execute.
module branch_predictor #(
    parameter int         IDX_W    = 6,
    parameter int         TAG_W    = 8,
    parameter logic [1:0] CNT_INIT = 2'b10
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_flush,
    input  logic        i_lookup_valid,
    input  logic [31:0] i_lookup_pc,
    output logic        o_pred_valid,
    output logic        o_pred_hit,
    output logic        o_pred_taken,
    output logic [31:0] o_pred_target,
    input  logic        i_upd_valid,
    input  logic [31:0] i_upd_pc,
    input  logic        i_upd_taken,
    input  logic [31:0] i_upd_target,
    input  logic        i_upd_pred_taken,
    output logic [31:0] o_lookup_cnt,
    output logic [31:0] o_mispred_cnt
);

    localparam int DEPTH = 1 << IDX_W;

    logic [DEPTH-1:0] valid_q;
    logic [1:0]       cnt_q    [DEPTH];
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic [31:0]      target_q [DEPTH];

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, lk_taken, up_hit, up_write;
    logic [31:0]      lk_target;
    logic             unused_pc_bits;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    assign lk_idx = i_lookup_pc[IDX_W+1:2];
    assign lk_tag = i_lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign up_idx = i_upd_pc[IDX_W+1:2];
    assign up_tag = i_upd_pc[IDX_W+TAG_W+1:IDX_W+2];

    // Only the index and tag fields of the update PC participate.
    assign unused_pc_bits = ^{i_upd_pc[1:0], i_upd_pc[31:IDX_W+TAG_W+2]};

    // Table reads use the pre-edge contents, which gives read-before-write
    // for same-cycle lookup/update and pre-flush visibility for free.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        lk_hit    = 1'b0;
        lk_taken  = 1'b0;
        lk_target = i_lookup_pc + 32'd4;
        up_hit    = 1'b0;
        up_write  = i_upd_valid && !i_flush;

        lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        lk_taken = lk_hit && cnt_q[lk_idx][1];
        if (lk_taken) begin
            lk_target = target_q[lk_idx];
        end
        up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    end

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_pred_valid  <= 1'b0;
            o_pred_hit    <= 1'b0;
            o_pred_taken  <= 1'b0;
            o_pred_target <= '0;
        end else begin
            o_pred_valid <= i_lookup_valid;
            if (i_lookup_valid) begin
                o_pred_hit    <= lk_hit;
                o_pred_taken  <= lk_taken;
                o_pred_target <= lk_target;
            end
        end
    end

    // Statistics are deliberately untouched by flush.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_lookup_cnt  <= '0;
            o_mispred_cnt <= '0;
        end else begin
            if (i_lookup_valid) begin
                o_lookup_cnt <= o_lookup_cnt + 32'd1;
            end
            if (i_upd_valid && (i_upd_pred_taken != i_upd_taken)) begin
                o_mispred_cnt <= o_mispred_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= 2'b00;
            end
        end else if (i_flush) begin
            valid_q <= '0;
        end else if (i_upd_valid) begin
            if (up_hit) begin
                cnt_q[up_idx] <= i_upd_taken ? sat_inc(cnt_q[up_idx]) : sat_dec(cnt_q[up_idx]);
            end else if (i_upd_taken) begin
                valid_q[up_idx] <= 1'b1;
                cnt_q[up_idx]   <= CNT_INIT;
            end
        end
    end

    // NOTE: tags and targets are plain storage without reset; the valid bits guard them.
    always_ff @(posedge i_clk) begin
        if (up_write && i_upd_taken) begin
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= i_upd_target;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized + directed bench for branch_predictor: a behavioural BTB model
// queues expected predictions; a negedge monitor pops and compares them.
module tb_branch_predictor;

    localparam int IDX_W = 6;
    localparam int TAG_W = 8;
    localparam int DEPTH = 1 << IDX_W;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        lookup_valid = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic        pred_valid, pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        upd_pred_taken = 1'b0;
    logic [31:0] lookup_cnt, mispred_cnt;

    branch_predictor #(.IDX_W(IDX_W), .TAG_W(TAG_W), .CNT_INIT(2'b10)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
        .i_lookup_valid(lookup_valid), .i_lookup_pc(lookup_pc),
        .o_pred_valid(pred_valid), .o_pred_hit(pred_hit),
        .o_pred_taken(pred_taken), .o_pred_target(pred_target),
        .i_upd_valid(upd_valid), .i_upd_pc(upd_pc), .i_upd_taken(upd_taken),
        .i_upd_target(upd_target), .i_upd_pred_taken(upd_pred_taken),
        .o_lookup_cnt(lookup_cnt), .o_mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          hit;
        bit          taken;
        int unsigned target;
    } pred_t;

    // Behavioural table: index/tag derived arithmetically from the PC.
    bit          m_valid [DEPTH];
    int unsigned m_tag   [DEPTH];
    int unsigned m_tgt   [DEPTH];
    int unsigned m_cnt   [DEPTH];
    int unsigned m_lookups = 0;
    int unsigned m_mispred = 0;

    pred_t exp_q[$];
    pred_t last = '{0, 0, 0};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned idx_of(input int unsigned pc);
        return (pc / 4) % DEPTH;
    endfunction

    function automatic int unsigned tag_of(input int unsigned pc);
        return (pc / (4 * DEPTH)) % (1 << TAG_W);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
    endfunction

    // One clock of stimulus: expectation from pre-edge model, model advances after the edge.
    task automatic step(input bit lv, input int unsigned lpc,
                        input bit uv, input int unsigned upc, input bit ut,
                        input int unsigned utgt, input bit upt, input bit fl);
        pred_t e;
        int unsigned li, ui;
        bit uhit;
        lookup_valid   = lv;  lookup_pc  = lpc;
        upd_valid      = uv;  upd_pc     = upc;
        upd_taken      = ut;  upd_target = utgt;
        upd_pred_taken = upt; flush      = fl;
        li = idx_of(lpc);
        e.hit    = m_valid[li] && (m_tag[li] == tag_of(lpc));
        e.taken  = e.hit && (m_cnt[li] >= 2);
        e.target = e.taken ? m_tgt[li] : lpc + 4;
        @(posedge clk);
        if (lv) begin
            m_lookups++;
            exp_q.push_back(e);
        end
        if (uv && (upt != ut)) m_mispred++;
        if (fl) begin
            model_clear();
        end else if (uv) begin
            ui   = idx_of(upc);
            uhit = m_valid[ui] && (m_tag[ui] == tag_of(upc));
            if (uhit) begin
                if (ut) begin
                    m_cnt[ui] = (m_cnt[ui] < 3) ? m_cnt[ui] + 1 : 3;
                    m_tgt[ui] = utgt;
                end else begin
                    m_cnt[ui] = (m_cnt[ui] > 0) ? m_cnt[ui] - 1 : 0;
                end
            end else if (ut) begin
                m_valid[ui] = 1;
                m_tag[ui]   = tag_of(upc);
                m_tgt[ui]   = utgt;
                m_cnt[ui]   = 2;
            end
        end
        #1;
        lookup_valid = 1'b0; upd_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic lookup(input int unsigned pc);
        step(1, pc, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic update(input int unsigned pc, input bit taken, input int unsigned tgt, input bit pt);
        step(0, 0, 1, pc, taken, tgt, pt, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset placed between clock edges; outputs must clear at once.
    task automatic async_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_pred_valid", {31'd0, pred_valid}, 32'd0);
        check("rst_pred_hit", {31'd0, pred_hit}, 32'd0);
        check("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        check("rst_pred_target", pred_target, 32'd0);
        check("rst_lookup_cnt", lookup_cnt, 32'd0);
        check("rst_mispred_cnt", mispred_cnt, 32'd0);
        model_clear();
        m_lookups = 0;
        m_mispred = 0;
        exp_q.delete();
        last = '{0, 0, 0};
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (pred_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pred_valid", 32'd1, 32'd0);
                end else begin
                    last = exp_q.pop_front();
                    check("pred_hit", {31'd0, pred_hit}, {31'd0, last.hit});
                    check("pred_taken", {31'd0, pred_taken}, {31'd0, last.taken});
                    check("pred_target", pred_target, last.target);
                end
            end else begin
                check("hold_hit", {31'd0, pred_hit}, {31'd0, last.hit});
                check("hold_taken", {31'd0, pred_taken}, {31'd0, last.taken});
                check("hold_target", pred_target, last.target);
            end
            check("lookup_cnt", lookup_cnt, m_lookups);
            check("mispred_cnt", mispred_cnt, m_mispred);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned pc, tgt, n_lk;
        model_clear();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Cold lookup misses and predicts fall-through.
        lookup(32'h100);
        // Allocate then hit.
        update(32'h100, 1, 32'h40, 0);
        lookup(32'h100);
        // Counter training: down to strongly not-taken, then saturate up.
        update(32'h100, 0, 32'h0, 1);
        update(32'h100, 0, 32'h0, 1);
        lookup(32'h100);
        for (int i = 0; i < 3; i++) update(32'h100, 1, 32'h40, 0);
        lookup(32'h100);
        update(32'h100, 0, 32'h0, 1);
        lookup(32'h100);
        idle(2);

        // Aliasing on index 0 with a different tag.
        update(32'h200, 1, 32'h80, 0);
        lookup(32'h100);
        lookup(32'h200);
        // Same-cycle lookup+update on one index sees the old entry.
        step(1, 32'h200, 1, 32'h100, 1, 32'hC0, 0, 0);
        lookup(32'h100);

        // Flush with concurrent update: update dropped, lookup sees pre-flush state.
        update(32'h300, 1, 32'h44, 0);
        step(1, 32'h300, 1, 32'h400, 1, 32'h48, 0, 1);
        lookup(32'h300);
        lookup(32'h400);
        lookup(32'h100);

        // Async reset mid-stream with traffic in flight.
        update(32'h500, 1, 32'h50, 0);
        step(1, 32'h500, 0, 0, 0, 0, 0, 0);
        async_reset();
        lookup(32'h500);

        // Wrap of the fall-through address and counter arithmetic.
        async_reset();
        lookup(32'hFFFF_FFFC);
        update(32'h10, 1, 32'h20, 0);
        update(32'h14, 0, 32'h0, 1);
        update(32'h18, 1, 32'h24, 0);
        update(32'h1C, 1, 32'h28, 1);
        update(32'h20, 0, 32'h0, 0);
        lookup(32'h10);
        lookup(32'h14);
        @(negedge clk);
        check("mispred_total", mispred_cnt, 32'd3);
        check("lookup_total", lookup_cnt, 32'd3);

        // Randomized traffic over a small PC pool to force hits and aliases.
        n_lk = 0;
        for (int i = 0; i < 3000; i++) begin
            int unsigned tg;
            tg = $urandom_range(0, 3);
            pc = (tg == 3 ? 32'hFF : tg) * (4 * DEPTH) + $urandom_range(0, 7) * 4;
            if ($urandom_range(0, 63) == 0) pc = 32'hFFFF_FFFC;
            tgt = $urandom & 32'hFFFF_FFFC;
            step($urandom_range(0, 3) != 0, pc,
                 $urandom_range(0, 1), ($urandom_range(0, 3) * (4 * DEPTH)) + $urandom_range(0, 7) * 4,
                 $urandom_range(0, 2) != 0, tgt, $urandom_range(0, 1),
                 $urandom_range(0, 99) == 0);
            if (lookup_valid) n_lk++;
        end

        idle(3);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
